// File: rtl/xsr_pkg.sv
// Shared types and helpers for the xoshiro256** companion blocks.
// The 256-bit state packs s1 in the low word up to s4 in the high word.
package xsr_pkg;

  localparam int unsigned XSR_W       = 64;
  localparam int unsigned XSR_STATE_W = 4 * XSR_W;

  localparam int unsigned S1_LSB = 0;
  localparam int unsigned S2_LSB = XSR_W;
  localparam int unsigned S3_LSB = 2 * XSR_W;
  localparam int unsigned S4_LSB = 3 * XSR_W;

  // The first packed member is the most significant, so s4 is listed first.
  typedef struct packed {
    logic [XSR_W-1:0] s4;
    logic [XSR_W-1:0] s3;
    logic [XSR_W-1:0] s2;
    logic [XSR_W-1:0] s1;
  } xsr_state_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_STEP,
    ST_EMIT,
    ST_DONE
  } xsr_fsm_e;

  function automatic logic [XSR_W-1:0] rotl64(input logic [XSR_W-1:0] x,
                                              input logic [5:0]       n);
    return (x << n) | (x >> (7'd64 - {1'b0, n}));
  endfunction

  function automatic logic [XSR_W-1:0] rotr64(input logic [XSR_W-1:0] x,
                                              input logic [5:0]       n);
    return (x >> n) | (x << (7'd64 - {1'b0, n}));
  endfunction

  // Generator output for a state, computed from its s2 word.
  function automatic logic [XSR_W-1:0] xsr_scramble(input logic [XSR_W-1:0] s2);
    logic [XSR_W-1:0] m;
    m = s2 * 64'd5;
    return rotl64(m, 6'd7) * 64'd9;
  endfunction

endpackage

// File: rtl/xsr_unstep.sv
// Combinational inverse of one xoshiro256** state transition.
// Recovers the state that the forward step turned into cur_state_i.
module xsr_unstep
  import xsr_pkg::*;
(
  input  logic [XSR_STATE_W-1:0] cur_state_i,
  output logic [XSR_STATE_W-1:0] prev_state_o
);

  logic [XSR_W-1:0] n1, n2, n3, n4;
  logic [XSR_W-1:0] a, u;
  logic [XSR_W-1:0] p1, p2, p3, p4;

  assign n1 = cur_state_i[S1_LSB +: XSR_W];
  assign n2 = cur_state_i[S2_LSB +: XSR_W];
  assign n3 = cur_state_i[S3_LSB +: XSR_W];
  assign n4 = cur_state_i[S4_LSB +: XSR_W];

  // a = s4^s2 before the forward rotate; u = s2 ^ (s2 << 17).
  assign a = rotr64(n4, 6'd45);
  assign u = n2 ^ n3;

  // x ^ (x << 17) is undone by xoring in the three further shifted copies.
  assign p2 = u ^ (u << 17) ^ (u << 34) ^ (u << 51);
  assign p1 = n1 ^ a;
  assign p3 = n2 ^ p2 ^ p1;
  assign p4 = a ^ p2;

  assign prev_state_o = {p4, p3, p2, p1};

endmodule

// File: rtl/xsr_rewind.sv
// Walks a loaded xoshiro256** state backwards, emitting each recovered
// earlier state with the generator output it produced, newest first.
module xsr_rewind
  import xsr_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   load_valid,
  output logic                   load_ready,
  input  logic [XSR_STATE_W-1:0] load_state,
  input  logic [CNT_W-1:0]       load_count,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [XSR_W-1:0]       out_value,
  output logic [XSR_STATE_W-1:0] out_state,
  output logic                   busy,
  output logic                   done
);

  xsr_fsm_e               fsm_q;
  logic [XSR_STATE_W-1:0] state_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [XSR_STATE_W-1:0] out_state_q;
  logic [XSR_W-1:0]       out_value_q;
  logic                   out_valid_q;
  logic                   done_q;
  logic                   busy_q;
  logic                   load_ready_q;

  logic [XSR_STATE_W-1:0] prev_state_d;
  xsr_state_t             prev_s;

  xsr_unstep u_unstep (
    .cur_state_i  (state_q),
    .prev_state_o (prev_state_d)
  );

  assign prev_s = prev_state_d;

  // NOTE: every register here, including the 256-bit state, is in the async
  // reset branch because a mid-run reset must return all outputs to zero.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // right-hand side reads the pre-edge value regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q        <= ST_IDLE;
      state_q      <= '0;
      cnt_q        <= '0;
      out_state_q  <= '0;
      out_value_q  <= '0;
      out_valid_q  <= 1'b0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
      load_ready_q <= 1'b1;
    end else begin
      done_q <= 1'b0;
      unique case (fsm_q)
        ST_IDLE: begin
          if (load_valid && load_ready_q) begin
            state_q      <= load_state;
            cnt_q        <= load_count;
            load_ready_q <= 1'b0;
            busy_q       <= 1'b1;
            // A zero-length run still reports completion through DONE.
            if (load_count == '0) begin
              done_q <= 1'b1;
              fsm_q  <= ST_DONE;
            end else begin
              fsm_q <= ST_STEP;
            end
          end
        end
        ST_STEP: begin
          state_q     <= prev_state_d;
          out_state_q <= prev_state_d;
          out_value_q <= xsr_scramble(prev_s.s2);
          out_valid_q <= 1'b1;
          cnt_q       <= cnt_q - CNT_W'(1);
          fsm_q       <= ST_EMIT;
        end
        ST_EMIT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            if (cnt_q != '0) begin
              fsm_q <= ST_STEP;
            end else begin
              done_q <= 1'b1;
              fsm_q  <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          busy_q       <= 1'b0;
          load_ready_q <= 1'b1;
          fsm_q        <= ST_IDLE;
        end
        default: fsm_q <= ST_IDLE;
      endcase
    end
  end

  assign load_ready = load_ready_q;
  assign out_valid  = out_valid_q;
  assign out_value  = out_value_q;
  assign out_state  = out_state_q;
  assign busy       = busy_q;
  assign done       = done_q;

  // A presented value must stay put until the consumer takes it.
  a_hold_payload : assert property (
    @(posedge clk) disable iff (!rst_n)
      (out_valid && !out_ready) |=> (out_valid && $stable(out_state) && $stable(out_value))
  );

  a_done_exclusive : assert property (
    @(posedge clk) disable iff (!rst_n) done |-> !out_valid
  );

endmodule

// File: tb/tb_xsr_rewind.sv
// Bench for xsr_rewind: a forward xoshiro256** model builds the expected
// reverse stream, checked every cycle, plus directed timing checks.
module tb_xsr_rewind;

  localparam int CNT_W = 32;
  localparam logic [63:0] GOLDEN = 64'h9e3779b97f4a7c15;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               load_valid = 1'b0;
  logic               load_ready;
  logic [255:0]       load_state = '0;
  logic [CNT_W-1:0]   load_count = '0;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic [63:0]        out_value;
  logic [255:0]       out_state;
  logic               busy;
  logic               done;

  typedef struct {
    logic [255:0] st;
    logic [63:0]  val;
  } exp_t;

  exp_t         exp_q[$];
  logic [255:0] last_acc = '0;
  int           n_checks = 0;
  int           n_fail = 0;

  xsr_rewind #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_state (load_state),
    .load_count (load_count),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_value  (out_value),
    .out_state  (out_state),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- forward generator model ----------------
  function automatic logic [63:0] m_rotl(input logic [63:0] x, input int k);
    return (x << k) | (x >> (64 - k));
  endfunction

  function automatic logic [63:0] m_out(input logic [255:0] st);
    logic [63:0] s2;
    s2 = st[127:64];
    return m_rotl(s2 * 64'd5, 7) * 64'd9;
  endfunction

  function automatic logic [255:0] m_next(input logic [255:0] st);
    logic [63:0] s0, s1, s2, s3, t;
    s0 = st[63:0];
    s1 = st[127:64];
    s2 = st[191:128];
    s3 = st[255:192];
    t  = s1 << 17;
    s2 = s2 ^ s0;
    s3 = s3 ^ s1;
    s1 = s1 ^ s2;
    s0 = s0 ^ s3;
    s2 = s2 ^ t;
    s3 = m_rotl(s3, 45);
    return {s3, s2, s1, s0};
  endfunction

  function automatic logic [63:0] sm_mix(input logic [63:0] x);
    logic [63:0] z;
    z = x;
    z = (z ^ (z >> 30)) * 64'hbf58476d1ce4e5b9;
    z = (z ^ (z >> 27)) * 64'h94d049bb133111eb;
    return z ^ (z >> 31);
  endfunction

  function automatic logic [255:0] sm_seed(input logic [63:0] seed);
    return {sm_mix(seed + 64'd4 * GOLDEN), sm_mix(seed + 64'd3 * GOLDEN),
            sm_mix(seed + 64'd2 * GOLDEN), sm_mix(seed + GOLDEN)};
  endfunction

  // Runs the model forward n steps and queues the reverse stream.
  task automatic prepare(input logic [255:0] start, input int n, output logic [255:0] fin);
    logic [255:0] st[$];
    exp_t e;
    st.push_back(start);
    for (int i = 0; i < n; i++) st.push_back(m_next(st[i]));
    for (int i = n - 1; i >= 0; i--) begin
      e.st  = st[i];
      e.val = m_out(st[i]);
      exp_q.push_back(e);
    end
    fin = st[n];
  endtask

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (exp_q.size() == 0) begin
        check("stray_out_valid", 256'(out_valid), 256'(0));
      end else begin
        check("stream_state", out_state, exp_q[0].st);
        check("stream_value", 256'(out_value), 256'(exp_q[0].val));
        if (out_ready) begin
          last_acc = out_state;
          void'(exp_q.pop_front());
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic load_run(input logic [255:0] st, input logic [CNT_W-1:0] cnt);
    int guard = 0;
    while (!load_ready && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    check("load_ready_wait", 256'(load_ready), 256'(1));
    load_valid = 1'b1;
    load_state = st;
    load_count = cnt;
    @(posedge clk); #1;
    load_valid = 1'b0;
  endtask

  task automatic wait_out_valid(input string name);
    int guard = 0;
    while (!out_valid && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    check(name, 256'(out_valid), 256'(1));
  endtask

  task automatic wait_done(input string name, input int budget);
    int c = 0;
    while (!done && c < budget) begin
      @(posedge clk); #1;
      c++;
    end
    check({name, "_done"}, 256'(done), 256'(1));
    check({name, "_drained"}, 256'(exp_q.size()), 256'(0));
    @(posedge clk); #1;
    check({name, "_done_pulse"}, 256'(done), 256'(0));
    check({name, "_ready_back"}, 256'(load_ready), 256'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] start, fin, snap;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 256'(out_valid), 256'(0));
    check("rst_done", 256'(done), 256'(0));
    check("rst_busy", 256'(busy), 256'(0));
    check("rst_load_ready", 256'(load_ready), 256'(1));
    check("rst_out_state", out_state, 256'(0));
    check("rst_out_value", 256'(out_value), 256'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single hand-computed step
    out_ready = 1'b1;
    start = {64'h0, 64'h0, 64'h1, 64'h0};
    prepare(start, 1, fin);
    check("t1_model_fwd", fin, {64'h0000200000000000, 64'h0000000000020000, 64'h1, 64'h1});
    load_run(fin, 1);
    check("t1_busy", 256'(busy), 256'(1));
    check("t1_no_valid_yet", 256'(out_valid), 256'(0));
    @(posedge clk); #1;
    check("t1_valid", 256'(out_valid), 256'(1));
    check("t1_state", out_state, {64'h0, 64'h0, 64'h1, 64'h0});
    check("t1_value", 256'(out_value), 256'(64'h1680));
    @(posedge clk); #1;
    check("t1_done", 256'(done), 256'(1));
    check("t1_valid_low", 256'(out_valid), 256'(0));
    check("t1_not_ready", 256'(load_ready), 256'(0));
    @(posedge clk); #1;
    check("t1_done_low", 256'(done), 256'(0));
    check("t1_ready_back", 256'(load_ready), 256'(1));
    check("t1_idle", 256'(busy), 256'(0));

    // 16-step rewind of a splitmix-seeded run
    start = sm_seed(64'd0);
    prepare(start, 16, fin);
    load_run(fin, 16);
    wait_done("t2", 100);
    check("t2_back_to_start", last_acc, start);

    // All-zero state is a fixed point
    prepare('0, 3, fin);
    load_run(fin, 3);
    wait_done("t3", 40);

    // Zero count
    load_run(sm_seed(64'd7), 0);
    check("t4_done", 256'(done), 256'(1));
    check("t4_no_valid", 256'(out_valid), 256'(0));
    check("t4_not_ready", 256'(load_ready), 256'(0));
    @(posedge clk); #1;
    check("t4_done_low", 256'(done), 256'(0));
    check("t4_ready_back", 256'(load_ready), 256'(1));

    // Backpressure with an ignored load in the middle
    out_ready = 1'b0;
    prepare(sm_seed(64'd1234), 4, fin);
    load_run(fin, 4);
    wait_out_valid("t5_first_valid");
    snap = out_state;
    load_valid = 1'b1;
    load_state = '1;
    load_count = 32'd5;
    repeat (5) begin
      @(posedge clk); #1;
      check("t5_held_valid", 256'(out_valid), 256'(1));
      check("t5_held_state", out_state, snap);
      check("t5_no_ready", 256'(load_ready), 256'(0));
    end
    load_valid = 1'b0;
    out_ready = 1'b1;
    wait_done("t5", 40);
    repeat (3) begin
      @(posedge clk); #1;
      check("t5_quiet", 256'(out_valid), 256'(0));
    end

    // Asynchronous reset during EMIT
    out_ready = 1'b0;
    prepare(sm_seed(64'd99), 8, fin);
    load_run(fin, 8);
    wait_out_valid("t6_first_valid");
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("t6_rst_valid", 256'(out_valid), 256'(0));
    check("t6_rst_state", out_state, 256'(0));
    check("t6_rst_value", 256'(out_value), 256'(0));
    check("t6_rst_busy", 256'(busy), 256'(0));
    check("t6_rst_ready", 256'(load_ready), 256'(1));
    check("t6_rst_done", 256'(done), 256'(0));
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      check("t6_no_done", 256'(done), 256'(0));
    end
    out_ready = 1'b1;
    start = sm_seed(64'd555);
    prepare(start, 2, fin);
    load_run(fin, 2);
    wait_done("t6_after", 30);
    check("t6_back_to_start", last_acc, start);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
